// File: rtl/i2s_master_ctrl.sv
// rtl/i2s_master_ctrl.sv - I2S master bclk/lrclk generator and frame-aligned capture sequencer
module i2s_master_ctrl #(
    parameter int DIV_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             sw_enable,
    input  logic [DIV_W-1:0] bclk_div,
    input  logic             fifo_ready,
    input  logic             overrun_clear,
    output logic             bclk,
    output logic             lrclk,
    output logic             shift_enable,
    output logic             running,
    output logic [CNT_W-1:0] overrun_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t           state, state_d;
    logic [DIV_W-1:0] div_q, div_q_d;
    logic [DIV_W-1:0] div_cnt, div_cnt_d;
    logic [5:0]       bit_cnt, bit_cnt_d;
    logic [5:0]       bit_next;
    logic             bclk_d, lrclk_d, shift_enable_d;
    logic             drain_wrap, drain_wrap_d;
    logic [CNT_W-1:0] overrun_d;
    logic             tick, fall_ev, rise_ev, overrun_ev;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            div_q         <= '0;
            div_cnt       <= '0;
            bit_cnt       <= '0;
            bclk          <= 1'b0;
            lrclk         <= 1'b0;
            shift_enable  <= 1'b0;
            drain_wrap    <= 1'b0;
            running       <= 1'b0;
            overrun_count <= '0;
        end else begin
            state         <= state_d;
            div_q         <= div_q_d;
            div_cnt       <= div_cnt_d;
            bit_cnt       <= bit_cnt_d;
            bclk          <= bclk_d;
            lrclk         <= lrclk_d;
            shift_enable  <= shift_enable_d;
            drain_wrap    <= drain_wrap_d;
            running       <= (state_d != S_IDLE);
            overrun_count <= overrun_d;
        end
    end

    always_comb begin
        state_d        = state;
        div_q_d        = div_q;
        div_cnt_d      = div_cnt;
        bit_cnt_d      = bit_cnt;
        bclk_d         = bclk;
        lrclk_d        = lrclk;
        shift_enable_d = shift_enable;
        drain_wrap_d   = drain_wrap;
        overrun_d      = overrun_count;

        tick       = (state != S_IDLE) && (div_cnt == div_q);
        fall_ev    = tick && bclk;
        rise_ev    = tick && !bclk;
        bit_next   = bit_cnt + 6'd1;
        // a stereo sample is dropped when its right-channel write (bit 0->1) finds the FIFO full
        overrun_ev = fall_ev && (bit_cnt == 6'd0) && !fifo_ready &&
                     ((state == S_RUN) || (state == S_DRAIN));

        if (state != S_IDLE) begin
            div_cnt_d = tick ? '0 : div_cnt + DIV_W'(1);
            if (tick) begin
                bclk_d = !bclk;
            end
            if (fall_ev) begin
                bit_cnt_d = bit_next;
                lrclk_d   = bit_next[5];
            end
        end

        case (state)
            S_IDLE: begin
                bclk_d         = 1'b0;
                lrclk_d        = 1'b0;
                div_cnt_d      = '0;
                bit_cnt_d      = '0;
                shift_enable_d = 1'b0;
                if (sw_enable) begin
                    state_d = S_START;
                    div_q_d = bclk_div;
                end
            end
            S_START: begin
                if (!sw_enable) begin
                    state_d = S_IDLE;
                end else if (fall_ev && (bit_cnt == 6'd63)) begin
                    state_d        = S_RUN;
                    shift_enable_d = 1'b1;
                end
            end
            S_RUN: begin
                shift_enable_d = 1'b1;
                if (!sw_enable) begin
                    state_d      = S_DRAIN;
                    drain_wrap_d = 1'b0;
                end
            end
            S_DRAIN: begin
                if (fall_ev && (bit_cnt == 6'd63)) begin
                    drain_wrap_d = 1'b1;
                end
                // stop only after the final right-channel word has been written
                if (rise_ev && (bit_cnt == 6'd2) && drain_wrap) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if ((state != S_IDLE) && (state_d == S_IDLE)) begin
            bclk_d         = 1'b0;
            lrclk_d        = 1'b0;
            div_cnt_d      = '0;
            bit_cnt_d      = '0;
            shift_enable_d = 1'b0;
        end

        if (overrun_clear) begin
            overrun_d = '0;
        end else if (overrun_ev && (overrun_count != '1)) begin
            overrun_d = overrun_count + CNT_W'(1);
        end
    end

endmodule
